branch_pc_unit: RTL

- Next-PC and branch-resolution stage directly downstream of the execute ALU.
- Consumes ALUResult and the Con_BLT/Con_BGT/zero flags, resolves conditional branches and JAL/JALR, and owns the architectural PC register.
- Detects misaligned control-flow targets and redirects to a trap vector, or halts.
- Keeps retired-branch and taken-branch performance counters.

---
 rtl/branch_pc_unit_if.sv | 34 +++
 rtl/branch_pc_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/branch_pc_unit_if.sv
// Execute-to-PC-unit bundle: ALU flags and control bits in, PC, redirect, trap and counter state out.
interface branch_pc_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  stall;
  logic                  Branch;
  logic                  Jump;
  logic                  Jalr;
  logic [2:0]            Funct3;
  logic [DATA_WIDTH-1:0] Imm;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Con_BLT;
  logic                  Con_BGT;
  logic                  zero;
  logic [DATA_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] PCPlus4;
  logic                  BrTaken;
  logic                  TrapPulse;
  logic [DATA_WIDTH-1:0] TrapPC;
  logic                  Halted;
  logic [CNT_WIDTH-1:0]  BranchCount;
  logic [CNT_WIDTH-1:0]  TakenCount;

  modport master (
    output stall, Branch, Jump, Jalr, Funct3, Imm, ALUResult, Con_BLT, Con_BGT, zero,
    input  PC, PCPlus4, BrTaken, TrapPulse, TrapPC, Halted, BranchCount, TakenCount
  );

  modport slave (
    input  stall, Branch, Jump, Jalr, Funct3, Imm, ALUResult, Con_BLT, Con_BGT, zero,
    output PC, PCPlus4, BrTaken, TrapPulse, TrapPC, Halted, BranchCount, TakenCount
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Branch resolution and architectural PC: picks the next fetch address, traps misaligned
// redirects, and counts resolved/taken conditional branches.
module branch_pc_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int                    HALT_ON_TRAP = 0,
  parameter int                    CNT_WIDTH    = 32
) (
  input logic             clk,
  input logic             reset,
  branch_pc_unit_if.slave bus
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt, trap_pc, trap_pc_nxt;
  logic                  trap_pulse, trap_pulse_nxt;
  logic [CNT_WIDTH-1:0]  br_cnt, br_cnt_nxt, tk_cnt, tk_cnt_nxt;
  logic                  cond, redirect, is_branch, misaligned, active;
  logic [DATA_WIDTH-1:0] pc_plus4, target;

  assign pc_plus4 = pc + DATA_WIDTH'(4);

  // BLTU/BGEU share Con_BLT: the ALU already chose signed/unsigned compare from Funct3
  always_comb begin
    cond = 1'b0;
    case (bus.Funct3)
      3'b000:  cond = bus.zero;
      3'b001:  cond = !bus.zero;
      3'b100:  cond = bus.Con_BLT;
      3'b101:  cond = !bus.Con_BLT;
      3'b110:  cond = bus.Con_BLT;
      3'b111:  cond = !bus.Con_BLT;
      default: cond = 1'b0;
    endcase
  end

  assign is_branch = bus.Branch && !bus.Jump && !bus.Jalr;
  assign redirect  = bus.Jalr || bus.Jump || (bus.Branch && cond);
  assign active    = (state == RUN) && !bus.stall;

  always_comb begin
    target = pc_plus4;
    if (bus.Jalr)                          target = {bus.ALUResult[DATA_WIDTH-1:1], 1'b0};
    else if (bus.Jump || (bus.Branch && cond)) target = pc + bus.Imm;
  end

  assign misaligned = redirect && target[1];

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    trap_pc_nxt    = trap_pc;
    trap_pulse_nxt = 1'b0;
    br_cnt_nxt     = br_cnt;
    tk_cnt_nxt     = tk_cnt;
    case (state)
      BOOT:   state_nxt = RUN;
      RUN: begin
        if (!bus.stall) begin
          if (misaligned) begin
            trap_pc_nxt    = pc;
            trap_pulse_nxt = 1'b1;
            if (HALT_ON_TRAP != 0) state_nxt = HALTED;
            else                   pc_nxt    = TRAP_VECTOR;
          end else begin
            pc_nxt = target;
          end
          // a taken branch counts even when its target traps
          if (is_branch) begin
            br_cnt_nxt = br_cnt + CNT_WIDTH'(1);
            if (cond) tk_cnt_nxt = tk_cnt + CNT_WIDTH'(1);
          end
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      trap_pc    <= '0;
      trap_pulse <= 1'b0;
      br_cnt     <= '0;
      tk_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      trap_pc    <= trap_pc_nxt;
      trap_pulse <= trap_pulse_nxt;
      br_cnt     <= br_cnt_nxt;
      tk_cnt     <= tk_cnt_nxt;
    end
  end

  // The ALU never reports less-than and greater-than together
  flag_consistency: assert property (@(posedge clk) disable iff (reset)
    !(bus.Branch && bus.Con_BLT && bus.Con_BGT));

  assign bus.PC          = pc;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.BrTaken     = redirect && active;
  assign bus.TrapPulse   = trap_pulse;
  assign bus.TrapPC      = trap_pc;
  assign bus.Halted      = (state == HALTED);
  assign bus.BranchCount = br_cnt;
  assign bus.TakenCount  = tk_cnt;
endmodule
